// File: rtl/ring_pkg.sv
// Shared ring-network definitions: flit geometry, flit-type encodings and
// the message-download FSM states.
package ring_pkg;

    localparam int FLIT_W    = 16;
    localparam int MAX_FLITS = 11;

    localparam logic [1:0] CTRL_IDLE = 2'b00;
    localparam logic [1:0] CTRL_HEAD = 2'b01;
    localparam logic [1:0] CTRL_BODY = 2'b10;
    localparam logic [1:0] CTRL_TAIL = 2'b11;

    typedef enum logic [1:0] {
        DL_IDLE = 2'd0,
        DL_BUSY = 2'd1,
        DL_FULL = 2'd2
    } dl_state_e;

endpackage

// File: rtl/m_req_download.sv
// Assembles ring flits into one MAX_FLITS-wide request message and holds it
// until memory takes it. Define M_REQ_DOWNLOAD_ERR_EN to enable err_out.
module m_req_download #(
    parameter int FLIT_W    = ring_pkg::FLIT_W,
    parameter int MAX_FLITS = ring_pkg::MAX_FLITS
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [FLIT_W-1:0]                flit_in,
    input  logic                             v_flit_in,
    input  logic [1:0]                       ctrl_in,
    input  logic                             mem_rdy,
    output logic                             download_rdy,
    output logic [FLIT_W*MAX_FLITS-1:0]      m_flits_req,
    output logic                             v_m_flits_req,
    output logic [$clog2(MAX_FLITS+1)-1:0]   m_flits_cnt,
    output logic                             m_download_state,
    output logic                             err_out
);
    import ring_pkg::*;

    localparam int MSG_W = FLIT_W * MAX_FLITS;
    localparam int CNT_W = $clog2(MAX_FLITS + 1);

`ifdef M_REQ_DOWNLOAD_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    dl_state_e          state_q, state_d;
    logic [MSG_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               accept;
    logic               wr_en;
    logic [CNT_W-1:0]   wr_slot;
    logic               err_evt;

    // Valid/ready: a flit moves only in a cycle where v_flit_in and
    // download_rdy are both high; the sender must hold it otherwise.
    assign download_rdy = (state_q != DL_FULL);
    assign accept       = v_flit_in & download_rdy;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_slot = cnt_q;
        err_evt = 1'b0;

        case (state_q)
            DL_IDLE: begin
                if (accept) begin
                    case (ctrl_in)
                        CTRL_HEAD, CTRL_TAIL: begin
                            data_d  = '0;
                            wr_en   = 1'b1;
                            wr_slot = '0;
                            cnt_d   = CNT_W'(1);
                            state_d = (ctrl_in == CTRL_TAIL) ? DL_FULL : DL_BUSY;
                        end
                        CTRL_BODY: err_evt = 1'b1;
                        default: ;
                    endcase
                end
            end
            DL_BUSY: begin
                if (accept) begin
                    case (ctrl_in)
                        CTRL_HEAD: begin
                            data_d  = '0;
                            wr_en   = 1'b1;
                            wr_slot = '0;
                            cnt_d   = CNT_W'(1);
                            err_evt = 1'b1;
                        end
                        CTRL_BODY: begin
                            wr_en = 1'b1;
                            cnt_d = cnt_q + CNT_W'(1);
                            // Last slot filled without a tail: truncate here.
                            if (cnt_q == CNT_W'(MAX_FLITS - 1)) begin
                                state_d = DL_FULL;
                                err_evt = 1'b1;
                            end
                        end
                        CTRL_TAIL: begin
                            wr_en   = 1'b1;
                            cnt_d   = cnt_q + CNT_W'(1);
                            state_d = DL_FULL;
                        end
                        default: ;
                    endcase
                end
            end
            DL_FULL: begin
                if (mem_rdy) begin
                    state_d = DL_IDLE;
                    data_d  = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = DL_IDLE;
                data_d  = '0;
                cnt_d   = '0;
            end
        endcase

        // Slot k sits at the MSB end, so flit 0 leads the message.
        for (int k = 0; k < MAX_FLITS; k++) begin
            if (wr_en && (wr_slot == CNT_W'(k))) begin
                data_d[MSG_W-1-FLIT_W*k -: FLIT_W] = flit_in;
            end
        end

        err_d = ERR_EN & err_evt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DL_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign m_flits_req      = data_q;
    assign v_m_flits_req    = (state_q == DL_FULL);
    assign m_flits_cnt      = cnt_q;
    assign m_download_state = (state_q != DL_IDLE);
    assign err_out          = err_q;

endmodule

// File: tb/tb_m_req_download.sv
// Randomized and directed bench for m_req_download against a queue-based
// message model; honours M_REQ_DOWNLOAD_ERR_EN for err_out expectations.
module tb_m_req_download;

    localparam int FLIT_W    = 16;
    localparam int MAX_FLITS = 11;
    localparam int MSG_W     = FLIT_W * MAX_FLITS;

    localparam logic [1:0] C_IDLE = 2'b00;
    localparam logic [1:0] C_HEAD = 2'b01;
    localparam logic [1:0] C_BODY = 2'b10;
    localparam logic [1:0] C_TAIL = 2'b11;

`ifdef M_REQ_DOWNLOAD_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              rst;
    logic [FLIT_W-1:0] flit_in;
    logic              v_flit_in;
    logic [1:0]        ctrl_in;
    logic              mem_rdy;
    logic              download_rdy;
    logic [MSG_W-1:0]  m_flits_req;
    logic              v_m_flits_req;
    logic [3:0]        m_flits_cnt;
    logic              m_download_state;
    logic              err_out;

    always #5 clk = ~clk;

    m_req_download dut (
        .clk              (clk),
        .rst              (rst),
        .flit_in          (flit_in),
        .v_flit_in        (v_flit_in),
        .ctrl_in          (ctrl_in),
        .mem_rdy          (mem_rdy),
        .download_rdy     (download_rdy),
        .m_flits_req      (m_flits_req),
        .v_m_flits_req    (v_m_flits_req),
        .m_flits_cnt      (m_flits_cnt),
        .m_download_state (m_download_state),
        .err_out          (err_out)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_pass   = 0;

    logic [FLIT_W-1:0] exp_q[$];   // flits of the message being built or held
    bit                holding;    // complete message waiting for memory
    bit                exp_err;

    task automatic check(input string tag, input logic [MSG_W-1:0] got,
                         input logic [MSG_W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [MSG_W-1:0] exp_msg();
        logic [MSG_W-1:0] r;
        r = '0;
        foreach (exp_q[k]) r[MSG_W-1-FLIT_W*k -: FLIT_W] = exp_q[k];
        return r;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        holding = 1'b0;
        exp_err = 1'b0;
    endtask

    // One clock of message-level behaviour, evaluated with pre-edge inputs.
    task automatic model_step(input bit v, input logic [1:0] c,
                              input logic [FLIT_W-1:0] f, input bit m);
        exp_err = 1'b0;
        if (holding) begin
            if (m) begin
                holding = 1'b0;
                exp_q.delete();
            end
        end else if (v) begin
            case (c)
                C_HEAD: begin
                    if (exp_q.size() > 0) exp_err = 1'b1;
                    exp_q.delete();
                    exp_q.push_back(f);
                end
                C_BODY: begin
                    if (exp_q.size() == 0) exp_err = 1'b1;
                    else begin
                        exp_q.push_back(f);
                        if (exp_q.size() == MAX_FLITS) begin
                            holding = 1'b1;
                            exp_err = 1'b1;
                        end
                    end
                end
                C_TAIL: begin
                    exp_q.push_back(f);
                    holding = 1'b1;
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_outputs();
        check("data",  m_flits_req, exp_msg());
        check("valid", MSG_W'(v_m_flits_req), MSG_W'(holding));
        check("cnt",   MSG_W'(m_flits_cnt), MSG_W'(exp_q.size()));
        check("state", MSG_W'(m_download_state), MSG_W'(exp_q.size() > 0));
        check("err",   MSG_W'(err_out), MSG_W'(ERR_EN & exp_err));
    endtask

    task automatic check_reset_values();
        check("rst_data",  m_flits_req, '0);
        check("rst_valid", MSG_W'(v_m_flits_req), '0);
        check("rst_cnt",   MSG_W'(m_flits_cnt), '0);
        check("rst_state", MSG_W'(m_download_state), '0);
        check("rst_err",   MSG_W'(err_out), '0);
        check("rst_rdy",   MSG_W'(download_rdy), MSG_W'(1));
    endtask

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic drive(input bit v, input logic [1:0] c,
                         input logic [FLIT_W-1:0] f, input bit m);
        v_flit_in = v;
        ctrl_in   = c;
        flit_in   = f;
        mem_rdy   = m;
        #1;
        check("rdy", MSG_W'(download_rdy), MSG_W'(!holding));
        model_step(v, c, f, m);
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-low-phase, released on a falling edge.
    task automatic pulse_reset();
        v_flit_in = 1'b0;
        ctrl_in   = C_IDLE;
        mem_rdy   = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [FLIT_W-1:0] digit_flit(input int k);
        logic [FLIT_W-1:0] r;
        for (int d = 0; d < 4; d++) r[15-4*d -: 4] = 4'((k + d) % 10);
        return r;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b0;
        flit_in   = '0;
        v_flit_in = 1'b0;
        ctrl_in   = C_IDLE;
        mem_rdy   = 1'b0;
        model_reset();
        #3;
        check_reset_values();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // single-flit message
        drive(1, C_TAIL, 16'hc0de, 0);
        check("single_data", m_flits_req, {16'hc0de, 160'h0});
        drive(0, C_IDLE, 16'h0, 1);

        // 3-flit message held while memory stalls, with back-pressure
        drive(1, C_HEAD, 16'habc1, 0);
        drive(1, C_BODY, 16'habc2, 0);
        drive(1, C_TAIL, 16'habc3, 0);
        for (int i = 0; i < 4; i++) drive(1, C_BODY, 16'h5555, 0);
        check("hold_data", m_flits_req, {16'habc1, 16'habc2, 16'habc3, 128'h0});
        drive(1, C_HEAD, 16'hdead, 1);   // FULL->IDLE cycle: refused
        drive(1, C_HEAD, 16'hdead, 0);   // accepted next cycle
        drive(1, C_TAIL, 16'hbeef, 0);
        drive(0, C_IDLE, 16'h0, 1);

        // 11-flit message with valid gaps
        for (int k = 0; k < MAX_FLITS; k++) begin
            if ($urandom_range(0, 1) == 1) drive(0, C_BODY, 16'hffff, 0);
            drive(1, (k == 0) ? C_HEAD : (k == MAX_FLITS - 1) ? C_TAIL : C_BODY,
                  digit_flit(k), 0);
        end
        check("max_cnt", MSG_W'(m_flits_cnt), MSG_W'(11));
        drive(0, C_IDLE, 16'h0, 1);

        // protocol errors: stray body, head mid-message, overflow
        drive(1, C_BODY, 16'h1111, 0);
        drive(1, C_HEAD, 16'h2222, 0);
        drive(1, C_BODY, 16'h3333, 0);
        drive(1, C_HEAD, 16'h4444, 0);
        check("restart_cnt", MSG_W'(m_flits_cnt), MSG_W'(1));
        for (int k = 1; k < MAX_FLITS; k++) drive(1, C_BODY, 16'(16'h4400 + k), 0);
        check("ovf_valid", MSG_W'(v_m_flits_req), MSG_W'(1));
        drive(1, C_IDLE, 16'h0, 1);

        // reset mid-message, then a clean message
        drive(1, C_HEAD, 16'h7001, 0);
        drive(1, C_BODY, 16'h7002, 0);
        pulse_reset();
        drive(1, C_HEAD, 16'h8001, 0);
        drive(1, C_BODY, 16'h8002, 0);
        drive(1, C_TAIL, 16'h8003, 0);
        check("post_rst_data", m_flits_req, {16'h8001, 16'h8002, 16'h8003, 128'h0});
        drive(0, C_IDLE, 16'h0, 1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [1:0] c;
            r = $urandom_range(0, 9);
            c = (r == 0) ? C_IDLE : (r < 3) ? C_HEAD : (r < 8) ? C_BODY : C_TAIL;
            if ($urandom_range(0, 299) == 0) pulse_reset();
            else drive($urandom_range(0, 3) != 0, c, 16'($urandom),
                       $urandom_range(0, 2) == 0);
        end

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
